cla_adder16: RTL and testbench

- 16-bit carry-lookahead adder with a registered output stage. The datapath is 4 groups of 4 bits with a second-level lookahead unit.
- Used as the core adder of carry-select and similar composite adders.
- Also exports the block propagate/generate terms, so it can be cascaded into a wider lookahead tree.

---
 rtl/cla_adder16.sv | 94 +++++++++
 tb/tb_cla_adder16.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cla_adder16.sv
// 16-bit two-level carry-lookahead adder (4 groups of 4 bits) with a registered
// result stage; also exports block propagate/generate for wider lookahead trees.
module cla_adder16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] ina,
  input  logic [15:0] inb,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ovf,
  output logic        grp_p,
  output logic        grp_g,
  output logic        out_valid
);

  logic [15:0] p;
  logic [15:0] g;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [16:0] c;
  logic [15:0] sum_c;
  logic        ovf_c;
  logic        bp_c;
  logic        bg_c;

  // Bit and group propagate/generate terms.
  always_comb begin
    p  = ina ^ inb;
    g  = ina & inb;
    gp = '0;
    gg = '0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Second-level lookahead for group carries, then in-group lookahead from each
  // group carry-in; nothing ripples between bits or groups.
  always_comb begin
    c      = '0;
    c[0]   = cin;
    c[4]   = gg[0] | (gp[0] & cin);
    c[8]   = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    c[12]  = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
           | (gp[2] & gp[1] & gp[0] & cin);
    c[16]  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
           | (gp[3] & gp[2] & gp[1] & gg[0])
           | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  // Block generate is the carry out with cin forced low.
  always_comb begin
    sum_c = p ^ c[15:0];
    ovf_c = c[16] ^ c[15];
    bp_c  = &gp;
    bg_c  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      grp_p     <= 1'b0;
      grp_g     <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= sum_c;
      cout      <= c[16];
      ovf       <= ovf_c;
      grp_p     <= bp_c;
      grp_g     <= bg_c;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_adder16.sv
// Self-checking bench for cla_adder16: directed corner cases followed by a
// back-to-back random run against an arithmetic reference model.
module tb_cla_adder16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] ina;
  logic [15:0] inb;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        grp_p;
  logic        grp_g;
  logic        out_valid;

  int n_vectors = 0;
  int n_miss    = 0;

  cla_adder16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ina       (ina),
    .inb       (inb),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .grp_p     (grp_p),
    .grp_g     (grp_g),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {grp_g, grp_p, ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci);
    logic [16:0] full;
    logic [16:0] nocin;
    logic        v;
    logic        bp;
    full  = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    nocin = {1'b0, a} + {1'b0, b};
    v     = (a[15] == b[15]) && (full[15] != a[15]);
    bp    = ((a ^ b) == 16'hFFFF);
    return {nocin[16], bp, v, full[16], full[15:0]};
  endfunction

  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] a,
                               input logic [15:0] b, input logic ci);
    rst      = r;
    in_valid = v;
    ina      = a;
    inb      = b;
    cin      = ci;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] e_sum, input logic e_cout,
                             input logic e_ovf, input logic e_gp, input logic e_gg,
                             input logic e_valid);
    n_vectors += 6;
    assert (sum === e_sum) else begin
      n_miss++;
      $error("[TB] FAIL %s.sum got %h expected %h", tag, sum, e_sum);
    end
    assert (cout === e_cout) else begin
      n_miss++;
      $error("[TB] FAIL %s.cout got %b expected %b", tag, cout, e_cout);
    end
    assert (ovf === e_ovf) else begin
      n_miss++;
      $error("[TB] FAIL %s.ovf got %b expected %b", tag, ovf, e_ovf);
    end
    assert (grp_p === e_gp) else begin
      n_miss++;
      $error("[TB] FAIL %s.grp_p got %b expected %b", tag, grp_p, e_gp);
    end
    assert (grp_g === e_gg) else begin
      n_miss++;
      $error("[TB] FAIL %s.grp_g got %b expected %b", tag, grp_g, e_gg);
    end
    assert (out_valid === e_valid) else begin
      n_miss++;
      $error("[TB] FAIL %s.out_valid got %b expected %b", tag, out_valid, e_valid);
    end
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [19:0] exp_v;

    applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 16'hABCD, 16'h1357, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("idle", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    checkOutput("full_chain", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("prop_cin1", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("prop_cin0", 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    applyStimulus(1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
    @(negedge clk);
    checkOutput("ovf_pos", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0);
    @(negedge clk);
    checkOutput("ovf_neg", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

    applyStimulus(1'b0, 1'b1, 16'h1234, 16'h4321, 1'b1);
    @(negedge clk);
    checkOutput("op_5556", 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold", 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    checkOutput("rst_prio", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 16'h00FF, 16'h0F01, 1'b0);
    @(negedge clk);
    checkOutput("post_rst", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      if (i % 97 == 0) b = ~a;
      applyStimulus(1'b0, 1'b1, a, b, ci);
      exp_v = model(a, b, ci);
      @(negedge clk);
      checkOutput("random", exp_v[15:0], exp_v[16], exp_v[17], exp_v[18], exp_v[19], 1'b1);
    end

    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    checkOutput("drain", exp_v[15:0], exp_v[16], exp_v[17], exp_v[18], exp_v[19], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
    $finish;
  end

endmodule
